// File: rtl/mult_pipe_if.sv
// mult_pipe_if -- handshake/operand bundle for mult_pipe.
//   in_valid/in_ready/x/y : operand channel (producer -> multiplier)
//   out_valid/out_ready/o : product channel (multiplier -> consumer)
//   tc                    : two's-complement select, only with MULT_PIPE_SIGNED_EN
// Modports: master = producer/consumer side, slave = multiplier side.
interface mult_pipe_if #(
  parameter int WIDTH = 8
);
  localparam int OUT_W = 2*WIDTH;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] o;
`ifdef MULT_PIPE_SIGNED_EN
  logic             tc;
`endif

  modport master (
    output in_valid, x, y, out_ready,
`ifdef MULT_PIPE_SIGNED_EN
    output tc,
`endif
    input  in_ready, out_valid, o
  );

  modport slave (
    input  in_valid, x, y, out_ready,
`ifdef MULT_PIPE_SIGNED_EN
    input  tc,
`endif
    output in_ready, out_valid, o
  );
endinterface

// File: rtl/mult_pipe.sv
// mult_pipe -- 3-stage pipelined WIDTH x WIDTH multiplier with valid/ready.
//   S1: AND-plane partial products
//   S2: carry-save (full/half adder) reduction to two rows
//   S3: Kogge-Stone prefix carry adder -> o
// Ports: clk, rst_n (async, active low), bus (mult_pipe_if.slave).
// Operands handshaked in cycle c are registered into S1 at the end of c;
// the product is on o with out_valid=1 in cycle c+3.
// A stall (out_valid && !out_ready) freezes every stage and drops in_ready.
// Optional: define MULT_PIPE_SIGNED_EN to add bus.tc, which selects
// Baugh-Wooley signed multiplication (sign terms inverted in S1, correction
// constant added in S2).
module mult_pipe #(
  parameter int WIDTH = 8,
  parameter int OUT_W = 2*WIDTH
) (
  input  logic       clk,
  input  logic       rst_n,
  mult_pipe_if.slave bus
);
  localparam int STAGES = 3;
  localparam int LVLS   = $clog2(OUT_W);

  logic              w_stall;
  logic              w_acc;
  logic [STAGES:1]   r_vld_pipe;

  assign w_stall       = r_vld_pipe[STAGES] & ~bus.out_ready;
  assign w_acc         = bus.in_valid & ~w_stall;
  assign bus.in_ready  = ~w_stall;
  assign bus.out_valid = r_vld_pipe[STAGES];

  // bubbles shift through like real entries; only a stall holds them
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)        r_vld_pipe <= '0;
    else if (!w_stall) r_vld_pipe <= {r_vld_pipe[STAGES-1:1], bus.in_valid};

  // ---------------- S1: partial-product plane ----------------
  logic [WIDTH-1:0][WIDTH-1:0] w_pp, r_pp;   // [row = y bit][col = x bit]

  always_comb begin
    w_pp = '0;
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++) begin
        w_pp[i][j] = bus.x[j] & bus.y[i];
`ifdef MULT_PIPE_SIGNED_EN
        // Baugh-Wooley: terms mixing exactly one sign bit are complemented
        if ((i == WIDTH-1) != (j == WIDTH-1)) w_pp[i][j] = w_pp[i][j] ^ bus.tc;
`endif
      end
  end

`ifdef MULT_PIPE_SIGNED_EN
  logic r_tc1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)     r_tc1 <= 1'b0;
    else if (w_acc) r_tc1 <= bus.tc;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)     r_pp <= '0;
    else if (w_acc) r_pp <= w_pp;

  // ---------------- S2: carry-save reduction ----------------
  function automatic logic [2*OUT_W-1:0] f_csa(input logic [OUT_W-1:0] a,
                                               input logic [OUT_W-1:0] b,
                                               input logic [OUT_W-1:0] c);
    logic [OUT_W-1:0] m;
    m = (a & b) | (a & c) | (b & c);
    return {a ^ b ^ c, m << 1};
  endfunction

  logic [OUT_W-1:0] w_s, w_c, w_row;
  logic [OUT_W-1:0] r_sum, r_cry;

  // Rows fold into the (sum, carry) pair one 3:2 layer at a time; carries
  // out of the top bit are dropped since the true product fits in OUT_W.
  always_comb begin
    w_s   = '0;
    w_c   = '0;
    w_row = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_row = '0;
      w_row[WIDTH-1:0] = r_pp[i];
      w_row = w_row << i;
      {w_s, w_c} = f_csa(w_s, w_c, w_row);
    end
`ifdef MULT_PIPE_SIGNED_EN
    // Baugh-Wooley correction: +2^WIDTH + 2^(2*WIDTH-1)
    if (r_tc1) begin
      w_row = '0;
      w_row[WIDTH]   = 1'b1;
      w_row[OUT_W-1] = 1'b1;
      {w_s, w_c} = f_csa(w_s, w_c, w_row);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sum <= '0;
      r_cry <= '0;
    end else if (r_vld_pipe[1] && !w_stall) begin
      r_sum <= w_s;
      r_cry <= w_c;
    end

  // ---------------- S3: Kogge-Stone carry-propagate adder ----------------
  logic [OUT_W-1:0] w_g, w_p, w_p0, w_gn, w_pn, w_sum;

  // Black cells combine (g,p); once a span reaches bit 0 only g is needed,
  // so those propagate terms go unused (grey cells after synthesis).
  always_comb begin
    w_g  = r_sum & r_cry;
    w_p  = r_sum ^ r_cry;
    w_p0 = w_p;
    w_gn = w_g;
    w_pn = w_p;
    for (int l = 0; l < LVLS; l++) begin
      w_gn = w_g;
      w_pn = w_p;
      for (int i = (1 << l); i < OUT_W; i++) begin
        w_gn[i] = w_g[i] | (w_p[i] & w_g[i-(1<<l)]);
        w_pn[i] = w_p[i] & w_p[i-(1<<l)];
      end
      w_g = w_gn;
      w_p = w_pn;
    end
    w_sum = w_p0 ^ {w_g[OUT_W-2:0], 1'b0};
  end

  logic [OUT_W-1:0] r_o;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                       r_o <= '0;
    else if (r_vld_pipe[2] && !w_stall) r_o <= w_sum;

  assign bus.o = r_o;
endmodule
